// File: rtl/usb_hid_mouse_report_merger.sv
// Merges HID mouse engine reports with host-injected motion/button overrides and
// presents one clamped report downstream over valid/ready; stalled reports coalesce.
module usb_hid_mouse_report_merger #(
  parameter int ACC_WIDTH    = 16,
  parameter int FLUSH_CYCLES = 60000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        mouse_valid_i,
  input  logic [7:0]  mouse_buttons_i,
  input  logic [7:0]  mouse_dx_i,
  input  logic [7:0]  mouse_dy_i,
  input  logic [7:0]  mouse_wheel_i,
  input  logic        inj_valid_i,
  output logic        inj_ready_o,
  input  logic [15:0] inj_dx_i,
  input  logic [15:0] inj_dy_i,
  input  logic [7:0]  inj_wheel_i,
  input  logic [7:0]  inj_btn_mask_i,
  input  logic [7:0]  inj_btn_val_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_buttons_o,
  output logic [7:0]  out_dx_o,
  output logic [7:0]  out_dy_o,
  output logic [7:0]  out_wheel_o,
  output logic        pending_o,
  output logic [15:0] coalesce_cnt_o
);
  localparam int SW = ACC_WIDTH + 2;
  localparam int TW = $clog2(FLUSH_CYCLES + 1);
  typedef logic signed [SW-1:0] sum_t;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam sum_t AMAX = sum_t'(2 ** (ACC_WIDTH - 1) - 1);
  localparam sum_t OMAX = sum_t'(127);

  function automatic sum_t sat(input sum_t v, input sum_t lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  state_t                        state_q;
  logic signed [ACC_WIDTH-1:0]   acc_q [3];
  logic signed [ACC_WIDTH-1:0]   acc_d [3];
  logic [7:0]                    mask_q, val_q, last_btn_q;
  logic                          dirty_q, dirty_d;
  logic [TW-1:0]                 timer_q;
  logic                          out_valid_q;
  logic [7:0]                    out_btn_q, out_dx_q, out_dy_q, out_w_q;
  logic                          pending_q;
  logic [15:0]                   coal_q;

  sum_t       sum [3], inj_v [3], mou_v [3], outv [3], nacc [3];
  logic       inj_acc, any_acc, emit_merge, coal_inc;
  logic [7:0] mask_eff, val_eff, btn_src, merged_btn;

  always_comb begin
    inj_acc  = inj_valid_i & enable_i;
    any_acc  = (acc_q[0] != '0) | (acc_q[1] != '0) | (acc_q[2] != '0);
    inj_v[0] = sum_t'(signed'(inj_dx_i));
    inj_v[1] = sum_t'(signed'(inj_dy_i));
    inj_v[2] = sum_t'(signed'(inj_wheel_i));
    mou_v[0] = sum_t'(signed'(mouse_dx_i));
    mou_v[1] = sum_t'(signed'(mouse_dy_i));
    mou_v[2] = sum_t'(signed'(mouse_wheel_i));
    emit_merge = (state_q == IDLE) && enable_i &&
                 (mouse_valid_i || dirty_q || (timer_q == TW'(FLUSH_CYCLES - 1) && any_acc));
    // Residue left after clamping stays in the accumulator for later reports.
    for (int i = 0; i < 3; i++) begin
      sum[i]   = sum_t'(acc_q[i]) + (inj_acc ? inj_v[i] : '0) + (mouse_valid_i ? mou_v[i] : '0);
      outv[i]  = sat(sum[i], OMAX);
      nacc[i]  = emit_merge ? sum[i] - outv[i] : sum[i];
      acc_d[i] = enable_i ? ACC_WIDTH'(sat(nacc[i], AMAX)) : '0;
    end
    mask_eff   = inj_acc ? inj_btn_mask_i : mask_q;
    val_eff    = inj_acc ? inj_btn_val_i  : val_q;
    btn_src    = mouse_valid_i ? mouse_buttons_i : last_btn_q;
    merged_btn = (btn_src & ~mask_eff) | (val_eff & mask_eff);
    coal_inc   = (state_q == HOLD) && mouse_valid_i;
    dirty_d    = dirty_q;
    if (!enable_i)                      dirty_d = 1'b0;
    else if (emit_merge)                dirty_d = 1'b0;
    else if (coal_inc)                  dirty_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      for (int i = 0; i < 3; i++) acc_q[i] <= '0;
      mask_q      <= '0;
      val_q       <= '0;
      last_btn_q  <= '0;
      dirty_q     <= 1'b0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_btn_q   <= '0;
      out_dx_q    <= '0;
      out_dy_q    <= '0;
      out_w_q     <= '0;
      pending_q   <= 1'b0;
      coal_q      <= '0;
    end else begin
      for (int i = 0; i < 3; i++) acc_q[i] <= acc_d[i];
      if (!enable_i) begin
        mask_q <= '0;
        val_q  <= '0;
      end else if (inj_acc) begin
        mask_q <= inj_btn_mask_i;
        val_q  <= inj_btn_val_i;
      end
      if (mouse_valid_i) last_btn_q <= mouse_buttons_i;
      dirty_q   <= dirty_d;
      pending_q <= (acc_d[0] != '0) | (acc_d[1] != '0) | (acc_d[2] != '0) | dirty_d;
      if (coal_inc && coal_q != 16'hFFFF) coal_q <= coal_q + 16'd1;
      if (!any_acc || !enable_i)  timer_q <= '0;
      else if (state_q == IDLE)   timer_q <= timer_q + TW'(1);
      case (state_q)
        IDLE: begin
          if (emit_merge) begin
            out_valid_q <= 1'b1;
            out_btn_q   <= merged_btn;
            out_dx_q    <= outv[0][7:0];
            out_dy_q    <= outv[1][7:0];
            out_w_q     <= outv[2][7:0];
            timer_q     <= '0;
            state_q     <= HOLD;
          end else if (!enable_i && mouse_valid_i) begin
            out_valid_q <= 1'b1;
            out_btn_q   <= mouse_buttons_i;
            out_dx_q    <= mouse_dx_i;
            out_dy_q    <= mouse_dy_i;
            out_w_q     <= mouse_wheel_i;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          // Bypass: newest report overwrites the held one and stays valid.
          if (!enable_i && mouse_valid_i) begin
            out_btn_q <= mouse_buttons_i;
            out_dx_q  <= mouse_dx_i;
            out_dy_q  <= mouse_dy_i;
            out_w_q   <= mouse_wheel_i;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inj_ready_o    = enable_i;
  assign out_valid_o    = out_valid_q;
  assign out_buttons_o  = out_btn_q;
  assign out_dx_o       = out_dx_q;
  assign out_dy_o       = out_dy_q;
  assign out_wheel_o    = out_w_q;
  assign pending_o      = pending_q;
  assign coalesce_cnt_o = coal_q;
endmodule
